// File: rtl/dport_arbiter_pkg.sv
// Shared request payload type and grant-selection helper for the data-port arbiter.
`include "riscv_defs.sv"

package dport_arbiter_pkg;

    localparam int XLEN = `RV_XLEN;

    typedef struct packed {
        logic [1:0]      size;
        logic            dvalid;
        logic [1:0]      hpl;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } dreq_t;

    // A held grant wins; otherwise round-robin on contention, else whoever asks.
    function automatic logic arb_select(
        input logic lock,
        input logic lock_id,
        input logic v0,
        input logic v1,
        input logic prio
    );
        logic s;
        if (lock) begin
            s = lock_id;
        end else if (v0 && v1) begin
            s = prio;
        end else if (v1) begin
            s = `RV_DPORT_M_AUX;
        end else begin
            s = `RV_DPORT_M_LSQ;
        end
        return s;
    endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO, 2**C_FIFO_DEPTH_X entries; data_o shows the head with zero latency.
// Push is ignored when full and pop when empty; flush_i empties it on the next enabled edge.
`include "riscv_defs.sv"

module fifo #(
    parameter int C_FIFO_WIDTH   = 1,
    parameter int C_FIFO_DEPTH_X = 2
) (
    input  logic                    clk_i,
    input  logic                    clk_en_i,
    input  logic                    resetb_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [C_FIFO_WIDTH-1:0] data_i,
    input  logic                    pop_i,
    output logic [C_FIFO_WIDTH-1:0] data_o,
    output logic                    empty_o,
    output logic                    full_o
);

    localparam int DEPTH = 1 << C_FIFO_DEPTH_X;
    localparam logic [C_FIFO_DEPTH_X:0] PTR_ONE = {{C_FIFO_DEPTH_X{1'b0}}, 1'b1};

    logic [C_FIFO_WIDTH-1:0]   mem_q [DEPTH];
    logic [C_FIFO_DEPTH_X:0]   wr_ptr_q, wr_ptr_d;
    logic [C_FIFO_DEPTH_X:0]   rd_ptr_q, rd_ptr_d;
    logic                      do_push;
    logic                      do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[C_FIFO_DEPTH_X] != rd_ptr_q[C_FIFO_DEPTH_X]) &&
                     (wr_ptr_q[C_FIFO_DEPTH_X-1:0] == rd_ptr_q[C_FIFO_DEPTH_X-1:0]);
    assign data_o  = mem_q[rd_ptr_q[C_FIFO_DEPTH_X-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clk_en_i) begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clk_en_i && do_push && !flush_i) begin
            mem_q[wr_ptr_q[C_FIFO_DEPTH_X-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/riscv_defs.sv
// Core-wide width and master-ID defines shared by the data-port logic.
// Guarded so it can be listed as a source and also included by dependent files.
`ifndef RISCV_DEFS_SV
`define RISCV_DEFS_SV

`define RV_XLEN 32

// Data-port master identifiers
`define RV_DPORT_M_LSQ (1'b0)
`define RV_DPORT_M_AUX (1'b1)

`endif

// File: rtl/dport_arbiter.sv
// Round-robin two-master arbiter for the data port; zero-latency request and response paths.
// Grant is locked while the memory stalls; issue is blocked while the order FIFO is full.
`include "riscv_defs.sv"

module dport_arbiter
    import dport_arbiter_pkg::*;
#(
    parameter int C_FIFO_DEPTH_X = 2
) (
    input  logic            clk_i,
    input  logic            clk_en_i,
    input  logic            resetb_i,

    output logic            m0_reqready_o,
    input  logic            m0_reqvalid_i,
    input  logic [1:0]      m0_reqsize_i,
    input  logic            m0_reqdvalid_i,
    input  logic [1:0]      m0_reqhpl_i,
    input  logic [XLEN-1:0] m0_reqaddr_i,
    input  logic [XLEN-1:0] m0_reqdata_i,
    input  logic            m0_rspready_i,
    output logic            m0_rspvalid_o,
    output logic            m0_rsprerr_o,
    output logic            m0_rspwerr_o,
    output logic [XLEN-1:0] m0_rspdata_o,

    output logic            m1_reqready_o,
    input  logic            m1_reqvalid_i,
    input  logic [1:0]      m1_reqsize_i,
    input  logic            m1_reqdvalid_i,
    input  logic [1:0]      m1_reqhpl_i,
    input  logic [XLEN-1:0] m1_reqaddr_i,
    input  logic [XLEN-1:0] m1_reqdata_i,
    input  logic            m1_rspready_i,
    output logic            m1_rspvalid_o,
    output logic            m1_rsprerr_o,
    output logic            m1_rspwerr_o,
    output logic [XLEN-1:0] m1_rspdata_o,

    input  logic            dreqready_i,
    output logic            dreqvalid_o,
    output logic [1:0]      dreqsize_o,
    output logic            dreqdvalid_o,
    output logic [1:0]      dreqhpl_o,
    output logic [XLEN-1:0] dreqaddr_o,
    output logic [XLEN-1:0] dreqdata_o,

    output logic            drspready_o,
    input  logic            drspvalid_i,
    input  logic            drsprerr_i,
    input  logic            drspwerr_i,
    input  logic [XLEN-1:0] drspdata_i,

    output logic            arb_orphan_o
);

    logic  prio_q, prio_d;
    logic  lock_q, lock_d;
    logic  lock_id_q, lock_id_d;
    logic  orphan_q, orphan_d;

    dreq_t m0_req, m1_req, req_sel;
    logic  sel;
    logic  sel_vld;
    logic  accept;
    logic  stall;

    logic  order_full;
    logic  order_empty;
    logic  order_head;
    logic  rsp_live;
    logic  head_rdy;
    logic  pop;

    assign m0_req = '{size: m0_reqsize_i, dvalid: m0_reqdvalid_i, hpl: m0_reqhpl_i,
                      addr: m0_reqaddr_i, data: m0_reqdata_i};
    assign m1_req = '{size: m1_reqsize_i, dvalid: m1_reqdvalid_i, hpl: m1_reqhpl_i,
                      addr: m1_reqaddr_i, data: m1_reqdata_i};

    // Request path
    assign sel     = arb_select(lock_q, lock_id_q, m0_reqvalid_i, m1_reqvalid_i, prio_q);
    assign req_sel = (sel == `RV_DPORT_M_AUX) ? m1_req : m0_req;
    assign sel_vld = (sel == `RV_DPORT_M_AUX) ? m1_reqvalid_i : m0_reqvalid_i;

    assign dreqvalid_o  = sel_vld & ~order_full;
    assign dreqsize_o   = req_sel.size;
    assign dreqdvalid_o = req_sel.dvalid;
    assign dreqhpl_o    = req_sel.hpl;
    assign dreqaddr_o   = req_sel.addr;
    assign dreqdata_o   = req_sel.data;

    assign m0_reqready_o = (sel == `RV_DPORT_M_LSQ) & dreqready_i & ~order_full;
    assign m1_reqready_o = (sel == `RV_DPORT_M_AUX) & dreqready_i & ~order_full;

    assign accept = dreqvalid_o & dreqready_i;
    assign stall  = dreqvalid_o & ~dreqready_i;

    // Response path: the head of the order FIFO names the owner of the next response.
    assign rsp_live    = drspvalid_i & ~order_empty;
    assign head_rdy    = (order_head == `RV_DPORT_M_AUX) ? m1_rspready_i : m0_rspready_i;
    assign drspready_o = rsp_live & head_rdy;
    assign pop         = drspvalid_i & drspready_o;

    assign m0_rspvalid_o = rsp_live & (order_head == `RV_DPORT_M_LSQ);
    assign m1_rspvalid_o = rsp_live & (order_head == `RV_DPORT_M_AUX);
    assign m0_rsprerr_o  = drsprerr_i;
    assign m0_rspwerr_o  = drspwerr_i;
    assign m0_rspdata_o  = drspdata_i;
    assign m1_rsprerr_o  = drsprerr_i;
    assign m1_rspwerr_o  = drspwerr_i;
    assign m1_rspdata_o  = drspdata_i;

    assign arb_orphan_o = orphan_q;

    always_comb begin
        prio_d    = prio_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        orphan_d  = orphan_q;
        if (accept) begin
            prio_d = ~sel;
            lock_d = 1'b0;
        end else if (stall) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end
        if (drspvalid_i && order_empty) begin
            orphan_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            prio_q    <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            orphan_q  <= 1'b0;
        end else if (clk_en_i) begin
            prio_q    <= prio_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            orphan_q  <= orphan_d;
        end
    end

    fifo #(
        .C_FIFO_WIDTH   (1),
        .C_FIFO_DEPTH_X (C_FIFO_DEPTH_X)
    ) u_order_fifo (
        .clk_i    (clk_i),
        .clk_en_i (clk_en_i),
        .resetb_i (resetb_i),
        .flush_i  (1'b0),
        .push_i   (accept),
        .data_i   (sel),
        .pop_i    (pop),
        .data_o   (order_head),
        .empty_o  (order_empty),
        .full_o   (order_full)
    );

endmodule

// File: tb/tb_dport_arbiter.sv
// Directed bench for dport_arbiter: routing, round-robin, stall lock, full FIFO, backpressure, orphan.
module tb_dport_arbiter;
    import dport_arbiter_pkg::*;

    logic            clk_i = 1'b0;
    logic            clk_en_i;
    logic            resetb_i;
    logic            m0_reqready_o, m1_reqready_o;
    logic            m0_reqvalid_i, m1_reqvalid_i;
    logic [1:0]      m0_reqsize_i, m1_reqsize_i;
    logic            m0_reqdvalid_i, m1_reqdvalid_i;
    logic [1:0]      m0_reqhpl_i, m1_reqhpl_i;
    logic [XLEN-1:0] m0_reqaddr_i, m1_reqaddr_i;
    logic [XLEN-1:0] m0_reqdata_i, m1_reqdata_i;
    logic            m0_rspready_i, m1_rspready_i;
    logic            m0_rspvalid_o, m1_rspvalid_o;
    logic            m0_rsprerr_o, m1_rsprerr_o;
    logic            m0_rspwerr_o, m1_rspwerr_o;
    logic [XLEN-1:0] m0_rspdata_o, m1_rspdata_o;
    logic            dreqready_i, dreqvalid_o;
    logic [1:0]      dreqsize_o;
    logic            dreqdvalid_o;
    logic [1:0]      dreqhpl_o;
    logic [XLEN-1:0] dreqaddr_o, dreqdata_o;
    logic            drspready_o;
    logic            drspvalid_i, drsprerr_i, drspwerr_i;
    logic [XLEN-1:0] drspdata_i;
    logic            arb_orphan_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    dport_arbiter #(.C_FIFO_DEPTH_X(2)) dut (
        .clk_i(clk_i), .clk_en_i(clk_en_i), .resetb_i(resetb_i),
        .m0_reqready_o(m0_reqready_o), .m0_reqvalid_i(m0_reqvalid_i), .m0_reqsize_i(m0_reqsize_i),
        .m0_reqdvalid_i(m0_reqdvalid_i), .m0_reqhpl_i(m0_reqhpl_i), .m0_reqaddr_i(m0_reqaddr_i),
        .m0_reqdata_i(m0_reqdata_i), .m0_rspready_i(m0_rspready_i), .m0_rspvalid_o(m0_rspvalid_o),
        .m0_rsprerr_o(m0_rsprerr_o), .m0_rspwerr_o(m0_rspwerr_o), .m0_rspdata_o(m0_rspdata_o),
        .m1_reqready_o(m1_reqready_o), .m1_reqvalid_i(m1_reqvalid_i), .m1_reqsize_i(m1_reqsize_i),
        .m1_reqdvalid_i(m1_reqdvalid_i), .m1_reqhpl_i(m1_reqhpl_i), .m1_reqaddr_i(m1_reqaddr_i),
        .m1_reqdata_i(m1_reqdata_i), .m1_rspready_i(m1_rspready_i), .m1_rspvalid_o(m1_rspvalid_o),
        .m1_rsprerr_o(m1_rsprerr_o), .m1_rspwerr_o(m1_rspwerr_o), .m1_rspdata_o(m1_rspdata_o),
        .dreqready_i(dreqready_i), .dreqvalid_o(dreqvalid_o), .dreqsize_o(dreqsize_o),
        .dreqdvalid_o(dreqdvalid_o), .dreqhpl_o(dreqhpl_o), .dreqaddr_o(dreqaddr_o),
        .dreqdata_o(dreqdata_o), .drspready_o(drspready_o), .drspvalid_i(drspvalid_i),
        .drsprerr_i(drsprerr_i), .drspwerr_i(drspwerr_i), .drspdata_i(drspdata_i),
        .arb_orphan_o(arb_orphan_o)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        m0_reqvalid_i = 0; m0_reqsize_i = 2'd2; m0_reqdvalid_i = 0; m0_reqhpl_i = 2'd3;
        m0_reqaddr_i = '0; m0_reqdata_i = '0; m0_rspready_i = 1;
        m1_reqvalid_i = 0; m1_reqsize_i = 2'd1; m1_reqdvalid_i = 0; m1_reqhpl_i = 2'd0;
        m1_reqaddr_i = '0; m1_reqdata_i = '0; m1_rspready_i = 1;
        dreqready_i = 0; drspvalid_i = 0; drsprerr_i = 0; drspwerr_i = 0; drspdata_i = '0;
    endtask

    task automatic do_reset();
        resetb_i = 0;
        idle_inputs();
        tick();
        tick();
        resetb_i = 1;
    endtask

    initial begin
        clk_en_i = 1;
        resetb_i = 0;
        idle_inputs();
        #3;
        chk("rst_dreqvalid", dreqvalid_o, 0);
        chk("rst_drspready", drspready_o, 0);
        chk("rst_orphan", arb_orphan_o, 0);
        chk("rst_rspvalid", {m0_rspvalid_o, m1_rspvalid_o}, 0);
        chk("rst_reqready", {m0_reqready_o, m1_reqready_o}, 0);
        tick();
        resetb_i = 1;

        // Single m0 load and its response
        tick();
        m0_reqvalid_i = 1; m0_reqaddr_i = 32'h100; dreqready_i = 1;
        settle();
        chk("t1_dreqvalid", dreqvalid_o, 1);
        chk("t1_addr", dreqaddr_o, 32'h100);
        chk("t1_size", dreqsize_o, 2'd2);
        chk("t1_hpl", dreqhpl_o, 2'd3);
        chk("t1_ready", {m0_reqready_o, m1_reqready_o}, 2'b10);
        tick();
        m0_reqvalid_i = 0;
        drspvalid_i = 1; drspdata_i = 32'hDEADBEEF;
        settle();
        chk("t1_rspvalid", {m0_rspvalid_o, m1_rspvalid_o}, 2'b10);
        chk("t1_rspdata", m0_rspdata_o, 32'hDEADBEEF);
        chk("t1_drspready", drspready_o, 1);
        tick();
        settle();
        chk("t1_empty_drspready", drspready_o, 0);
        chk("t1_empty_rspvalid", {m0_rspvalid_o, m1_rspvalid_o}, 2'b00);
        drspvalid_i = 0;

        // Round-robin with both masters valid
        do_reset();
        m0_reqvalid_i = 1; m0_reqaddr_i = 32'h200;
        m1_reqvalid_i = 1; m1_reqaddr_i = 32'h300; m1_reqdvalid_i = 1; m1_reqdata_i = 32'h55;
        dreqready_i = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("t2_addr%0d", i), dreqaddr_o, (i % 2 == 0) ? 32'h200 : 32'h300);
            chk($sformatf("t2_rdy%0d", i), {m0_reqready_o, m1_reqready_o},
                (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
        end
        m0_reqvalid_i = 0; m1_reqvalid_i = 0;
        for (int k = 1; k <= 4; k++) begin
            drspvalid_i = 1; drspdata_i = k;
            settle();
            chk($sformatf("t2_route%0d", k), {m0_rspvalid_o, m1_rspvalid_o},
                (k % 2 == 1) ? 2'b10 : 2'b01);
            chk($sformatf("t2_data%0d", k), (k % 2 == 1) ? m0_rspdata_o : m1_rspdata_o, k);
            tick();
        end
        drspvalid_i = 0;

        // Stall lock: m1 held for 3 cycles while m0 arrives
        do_reset();
        m1_reqvalid_i = 1; m1_reqaddr_i = 32'h400; m1_reqdvalid_i = 1; m1_reqdata_i = 32'hAAAA;
        dreqready_i = 0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) begin
                m0_reqvalid_i = 1; m0_reqaddr_i = 32'h500;
            end
            settle();
            chk($sformatf("t3_hold_addr%0d", c), dreqaddr_o, 32'h400);
            chk($sformatf("t3_hold_wr%0d", c), dreqdvalid_o, 1);
            chk($sformatf("t3_hold_rdy%0d", c), {m0_reqready_o, m1_reqready_o}, 2'b00);
            tick();
        end
        dreqready_i = 1;
        settle();
        chk("t3_c4_addr", dreqaddr_o, 32'h400);
        chk("t3_c4_rdy", {m0_reqready_o, m1_reqready_o}, 2'b01);
        tick();
        m1_reqvalid_i = 0;
        settle();
        chk("t3_c5_addr", dreqaddr_o, 32'h500);
        chk("t3_c5_rdy", {m0_reqready_o, m1_reqready_o}, 2'b10);
        tick();
        m0_reqvalid_i = 0;

        // Full order FIFO blocks the 5th request until a pop has happened
        do_reset();
        m0_reqvalid_i = 1; m0_reqaddr_i = 32'h600; dreqready_i = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("t4_issue%0d", i), dreqvalid_o, 1);
            tick();
        end
        settle();
        chk("t4_full_vld", dreqvalid_o, 0);
        chk("t4_full_rdy", m0_reqready_o, 0);
        drspvalid_i = 1; drspdata_i = 32'h11;
        settle();
        chk("t4_pop_rdy", drspready_o, 1);
        chk("t4_pop_same_vld", dreqvalid_o, 0);
        tick();
        drspvalid_i = 0;
        settle();
        chk("t4_resume_vld", dreqvalid_o, 1);
        chk("t4_resume_rdy", m0_reqready_o, 1);
        tick();
        m0_reqvalid_i = 0;

        // Response backpressure from the owning master
        do_reset();
        m0_reqvalid_i = 1; m0_reqaddr_i = 32'h700; dreqready_i = 1;
        tick();
        m0_reqvalid_i = 0;
        drspvalid_i = 1; drspdata_i = 32'h77; drsprerr_i = 1; m0_rspready_i = 0;
        settle();
        chk("t5_bp_drspready", drspready_o, 0);
        chk("t5_bp_rspvalid", m0_rspvalid_o, 1);
        chk("t5_rerr", m0_rsprerr_o, 1);
        tick();
        settle();
        chk("t5_pending", m0_rspvalid_o, 1);
        m0_rspready_i = 1;
        settle();
        chk("t5_done_drspready", drspready_o, 1);
        tick();
        drspvalid_i = 0; drsprerr_i = 0;

        // Clock enable low: accept does not push, orphan does not latch
        do_reset();
        clk_en_i = 0;
        m0_reqvalid_i = 1; m0_reqaddr_i = 32'h800; dreqready_i = 1;
        settle();
        chk("t6_cen_vld", dreqvalid_o, 1);
        tick();
        m0_reqvalid_i = 0;
        drspvalid_i = 1;
        settle();
        chk("t6_cen_nopush", drspready_o, 0);
        tick();
        settle();
        chk("t6_cen_orphan", arb_orphan_o, 0);
        drspvalid_i = 0;
        clk_en_i = 1;

        // Orphan response, then reset mid-stream
        tick();
        drspvalid_i = 1; drspdata_i = 32'h99;
        settle();
        chk("t7_orph_drspready", drspready_o, 0);
        chk("t7_orph_before", arb_orphan_o, 0);
        tick();
        settle();
        chk("t7_orph_set", arb_orphan_o, 1);
        drspvalid_i = 0;
        tick();
        settle();
        chk("t7_orph_sticky", arb_orphan_o, 1);
        m0_reqvalid_i = 1; m0_reqaddr_i = 32'h900; dreqready_i = 1;
        tick();
        m0_reqvalid_i = 0;
        resetb_i = 0;
        settle();
        chk("t7_rst_orphan", arb_orphan_o, 0);
        chk("t7_rst_dreqvalid", dreqvalid_o, 0);
        tick();
        resetb_i = 1;
        drspvalid_i = 1;
        settle();
        chk("t7_flushed", drspready_o, 0);
        chk("t7_flushed_rspvalid", m0_rspvalid_o, 0);
        tick();
        settle();
        chk("t7_orph_after_rst", arb_orphan_o, 1);
        drspvalid_i = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
